packet_mem_responder: RTL

Responder end of the packet-fetch interface. Holds the command-packet stream for one run in on-chip storage, filled by a host load port. Serves single-word read requests from the packet controller with fixed latency, and raises `stream_end` once the last loaded packet has been returned. Sits between the host/testbench loader and the packet controller / command FIFO / decoder / RS dispatch chain.

---
 rtl/packet_mem_if.sv | 32 +++
 rtl/packet_mem_responder.sv | 128 ++++++++++++
 2 files changed

// File: rtl/packet_mem_if.sv
// Host-load and controller-read bus of the packet memory responder.
// The master side is the loader/controller and the slave side is the responder.
interface packet_mem_if #(
  parameter int unsigned PACKET_W = 16,
  parameter int unsigned DEPTH    = 256
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic                load_valid;
  logic [PACKET_W-1:0] load_data;
  logic                load_last;
  logic                load_ready;
  logic                rd_en;
  logic [AW-1:0]       rd_addr;
  logic [PACKET_W-1:0] rd_data;
  logic                rd_valid;
  logic                replay;
  logic                stream_end;
  logic                bank_busy;
  logic                addr_err;
  logic [AW:0]         num_packets;

  modport master (
    output load_valid, load_data, load_last, rd_en, rd_addr, replay,
    input  load_ready, rd_data, rd_valid, stream_end, bank_busy, addr_err, num_packets
  );

  modport slave (
    input  load_valid, load_data, load_last, rd_en, rd_addr, replay,
    output load_ready, rd_data, rd_valid, stream_end, bank_busy, addr_err, num_packets
  );
endinterface

// File: rtl/packet_mem_responder.sv
// Packet storage loaded by the host and read back by the packet controller with fixed latency.
// Defining PACKET_MEM_OUTREG_EN adds a second output register, giving a 2-cycle read latency.
module packet_mem_responder #(
  parameter int unsigned PACKET_W = 16,
  parameter int unsigned DEPTH    = 256
) (
  input logic         clk,
  input logic         reset,
  packet_mem_if.slave bus
);
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, READY, FULL_ERR} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [PACKET_W-1:0] r_mem [DEPTH];
  logic [AW:0]         r_wptr;
  logic [AW-1:0]       r_last_addr;
  logic                r_load_ready;
  logic                r_bank_busy;
  logic                r_addr_err;
  logic                r_stream_end;
  logic                r_vld1;
  logic [PACKET_W-1:0] r_dat1;
  logic                w_wr;
  logic                w_rd;
  logic                w_in_range;
  logic                w_replay;
  logic                w_end_hit;
  logic                w_end_set;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next state plus write/read qualification; a write into a full store traps in FULL_ERR.
  always_comb begin
    w_next     = r_state;
    w_wr       = 1'b0;
    w_rd       = 1'b0;
    case (r_state)
      IDLE, LOAD: begin
        if (bus.load_valid) begin
          if (r_wptr == FULL_CNT) begin
            w_next = FULL_ERR;
          end else begin
            w_wr   = 1'b1;
            w_next = bus.load_last ? READY : LOAD;
          end
        end
      end
      READY:    w_rd = bus.rd_en;
      FULL_ERR: w_next = FULL_ERR;
      default:  w_next = IDLE;
    endcase
    w_replay   = (r_state == READY) && bus.replay;
    w_in_range = (bus.rd_addr <= r_last_addr);
    // A replay in the same cycle as the last-address read suppresses that stream_end.
    w_end_hit  = w_rd && (bus.rd_addr == r_last_addr) && !bus.replay;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr       <= '0;
      r_last_addr  <= '0;
      r_load_ready <= 1'b1;
      r_bank_busy  <= 1'b1;
      r_addr_err   <= 1'b0;
      r_stream_end <= 1'b0;
      r_vld1       <= 1'b0;
      r_dat1       <= '0;
    end else begin
      r_load_ready <= (w_next == IDLE) || (w_next == LOAD);
      r_bank_busy  <= (w_next != READY);
      r_vld1       <= w_rd;
      if (w_wr) begin
        r_wptr <= r_wptr + (AW+1)'(1);
        if (bus.load_last) r_last_addr <= r_wptr[AW-1:0];
      end
      if (w_rd) begin
        r_dat1 <= w_in_range ? r_mem[bus.rd_addr] : '0;
        if (!w_in_range) r_addr_err <= 1'b1;
      end
      if (w_replay)       r_stream_end <= 1'b0;
      else if (w_end_set) r_stream_end <= 1'b1;
    end
  end

  // Storage array has no reset.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= bus.load_data;
  end

`ifdef PACKET_MEM_OUTREG_EN
  logic                r_hit1;
  logic                r_vld2;
  logic [PACKET_W-1:0] r_dat2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hit1 <= 1'b0;
      r_vld2 <= 1'b0;
      r_dat2 <= '0;
    end else begin
      r_hit1 <= w_end_hit;
      r_vld2 <= r_vld1;
      r_dat2 <= r_dat1;
    end
  end

  assign w_end_set    = r_hit1;
  assign bus.rd_valid = r_vld2;
  assign bus.rd_data  = r_dat2;
`else
  assign w_end_set    = w_end_hit;
  assign bus.rd_valid = r_vld1;
  assign bus.rd_data  = r_dat1;
`endif

  assign bus.load_ready  = r_load_ready;
  assign bus.bank_busy   = r_bank_busy;
  assign bus.addr_err    = r_addr_err;
  assign bus.stream_end  = r_stream_end;
  assign bus.num_packets = r_wptr;
endmodule
